// File: rtl/vx_rop_csr_bank.sv
// Per-warp ROP control-state bank: CSR writes land in shadow registers and a
// COMMIT promotes them to the active state once the warp's ROP work drains.
module vx_rop_csr_bank #(
    parameter int          CORE_ID     = 0,
    parameter int          NUM_WARPS   = 4,
    parameter int          NUM_THREADS = 4,
    parameter int          RT_BITS     = 3,
    parameter int          SAMPLE_BITS = 2,
    parameter logic [11:0] CSR_BASE    = 12'h7D0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  write_enable,
    input  logic [11:0]                           write_addr,
    input  logic [$clog2(NUM_WARPS)-1:0]          write_wid,
    input  logic [NUM_THREADS-1:0]                write_tmask,
    input  logic [NUM_THREADS*32-1:0]             write_data,
    input  logic                                  read_enable,
    input  logic [11:0]                           read_addr,
    input  logic [$clog2(NUM_WARPS)-1:0]          read_wid,
    output logic                                  read_valid,
    output logic [NUM_THREADS*32-1:0]             read_data,
    input  logic [NUM_WARPS-1:0]                  rop_busy,
    output logic [NUM_WARPS*RT_BITS-1:0]          rop_rt_idx,
    output logic [NUM_WARPS*SAMPLE_BITS-1:0]      rop_sample_idx,
    output logic [NUM_WARPS-1:0]                  commit_pending
);

    localparam int          WID_BITS       = $clog2(NUM_WARPS);
    localparam logic [11:0] ADDR_RT        = CSR_BASE;
    localparam logic [11:0] ADDR_SAMPLE    = CSR_BASE + 12'd1;
    localparam logic [11:0] ADDR_COMMIT    = CSR_BASE + 12'd2;
    localparam logic [11:0] ADDR_STATUS    = CSR_BASE + 12'd3;
    localparam int          UNUSED_CORE_ID = CORE_ID;

    logic [RT_BITS-1:0]          shadow_rt_r     [NUM_WARPS];
    logic [SAMPLE_BITS-1:0]      shadow_sample_r [NUM_WARPS];
    logic [RT_BITS-1:0]          active_rt_r     [NUM_WARPS];
    logic [SAMPLE_BITS-1:0]      active_sample_r [NUM_WARPS];
    logic [NUM_WARPS-1:0]        pending_r;
    logic                        read_valid_r;
    logic [NUM_THREADS*32-1:0]   read_data_r;

    logic [NUM_THREADS-1:0]      lowest_lane_s;
    logic [31:0]                 wr_value_s;
    logic                        wr_active_s;
    logic                        wr_rt_s;
    logic                        wr_sample_s;
    logic                        wr_commit_s;
    logic [NUM_WARPS-1:0]        wr_hit_s;
    logic [NUM_WARPS-1:0]        apply_s;
    logic [NUM_WARPS-1:0]        pending_next_s;
    logic [31:0]                 rd_word_s;
    logic                        unused_value_s;

    // Pick the data lane of the lowest active thread (one-hot via two's complement)
    always_comb begin
        lowest_lane_s = write_tmask & (~write_tmask + {{(NUM_THREADS-1){1'b0}}, 1'b1});
        wr_value_s    = 32'd0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            wr_value_s = wr_value_s | (write_data[i*32 +: 32] & {32{lowest_lane_s[i]}});
        end
    end

    assign unused_value_s = ^wr_value_s;
    assign wr_active_s    = write_enable & (|write_tmask);
    assign wr_rt_s        = wr_active_s & (write_addr == ADDR_RT);
    assign wr_sample_s    = wr_active_s & (write_addr == ADDR_SAMPLE);
    assign wr_commit_s    = wr_active_s & (write_addr == ADDR_COMMIT);

    // Per-warp commit decision: apply when idle, otherwise remember the request
    always_comb begin
        wr_hit_s       = {NUM_WARPS{1'b0}};
        apply_s        = {NUM_WARPS{1'b0}};
        pending_next_s = pending_r;
        for (int w = 0; w < NUM_WARPS; w++) begin
            wr_hit_s[w] = (write_wid == WID_BITS'(w));
            if (!rop_busy[w]) begin
                apply_s[w]        = pending_r[w] | (wr_commit_s & wr_hit_s[w]);
                pending_next_s[w] = 1'b0;
            end else begin
                apply_s[w]        = 1'b0;
                pending_next_s[w] = pending_r[w] | (wr_commit_s & wr_hit_s[w]);
            end
        end
    end

    // Shadow, active and pending state; commits copy the shadow as of cycle start
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                shadow_rt_r[w]     <= {RT_BITS{1'b0}};
                shadow_sample_r[w] <= {SAMPLE_BITS{1'b0}};
                active_rt_r[w]     <= {RT_BITS{1'b0}};
                active_sample_r[w] <= {SAMPLE_BITS{1'b0}};
            end
            pending_r <= {NUM_WARPS{1'b0}};
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (apply_s[w]) begin
                    active_rt_r[w]     <= shadow_rt_r[w];
                    active_sample_r[w] <= shadow_sample_r[w];
                end
                if (wr_rt_s && wr_hit_s[w]) begin
                    shadow_rt_r[w] <= wr_value_s[RT_BITS-1:0];
                end
                if (wr_sample_s && wr_hit_s[w]) begin
                    shadow_sample_r[w] <= wr_value_s[SAMPLE_BITS-1:0];
                end
            end
            pending_r <= pending_next_s;
        end
    end

    // Read-port word selection from the register values at cycle start
    always_comb begin
        rd_word_s = 32'd0;
        case (read_addr)
            ADDR_RT:     rd_word_s = 32'(shadow_rt_r[read_wid]);
            ADDR_SAMPLE: rd_word_s = 32'(shadow_sample_r[read_wid]);
            ADDR_STATUS: begin
                rd_word_s[0]                 = pending_r[read_wid];
                rd_word_s[4 +: RT_BITS]      = active_rt_r[read_wid];
                rd_word_s[16 +: SAMPLE_BITS] = active_sample_r[read_wid];
            end
            default:     rd_word_s = 32'd0;
        endcase
    end

    // Registered read port; data holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid_r <= 1'b0;
            read_data_r  <= {(NUM_THREADS*32){1'b0}};
        end else begin
            read_valid_r <= read_enable;
            if (read_enable) begin
                read_data_r <= {NUM_THREADS{rd_word_s}};
            end
        end
    end

    assign read_valid     = read_valid_r;
    assign read_data      = read_data_r;
    assign commit_pending = pending_r;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_out
        assign rop_rt_idx[w*RT_BITS +: RT_BITS]             = active_rt_r[w];
        assign rop_sample_idx[w*SAMPLE_BITS +: SAMPLE_BITS] = active_sample_r[w];
    end

`ifdef DBG_TRACE_ROP
    // Trace of CSR writes and commit applies
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_active_s) begin
                $display("%t: core%0d-rop-csr-write: wid=%0d, addr=0x%0h, value=0x%0h",
                         $time, UNUSED_CORE_ID, write_wid, write_addr, wr_value_s);
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (apply_s[w]) begin
                    $display("%t: core%0d-rop-csr-commit: wid=%0d, addr=0x%0h, rt=%0d, sample=%0d",
                             $time, UNUSED_CORE_ID, w, ADDR_COMMIT, shadow_rt_r[w], shadow_sample_r[w]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_rop_csr_bank.sv
// Self-checking bench for vx_rop_csr_bank: directed test-plan scenarios followed
// by randomized traffic, all checked against a field-level behavioural model.
module tb_vx_rop_csr_bank;

    localparam int          NW   = 4;
    localparam int          NT   = 4;
    localparam int          RTB  = 3;
    localparam int          SB   = 2;
    localparam logic [11:0] BASE = 12'h7D0;

    logic               clk = 1'b0;
    logic               reset;
    logic               write_enable;
    logic [11:0]        write_addr;
    logic [1:0]         write_wid;
    logic [NT-1:0]      write_tmask;
    logic [NT*32-1:0]   write_data;
    logic               read_enable;
    logic [11:0]        read_addr;
    logic [1:0]         read_wid;
    logic               read_valid;
    logic [NT*32-1:0]   read_data;
    logic [NW-1:0]      rop_busy;
    logic [NW*RTB-1:0]  rop_rt_idx;
    logic [NW*SB-1:0]   rop_sample_idx;
    logic [NW-1:0]      commit_pending;

    vx_rop_csr_bank #(
        .CORE_ID(0), .NUM_WARPS(NW), .NUM_THREADS(NT),
        .RT_BITS(RTB), .SAMPLE_BITS(SB), .CSR_BASE(BASE)
    ) dut (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_addr(write_addr), .write_wid(write_wid),
        .write_tmask(write_tmask), .write_data(write_data),
        .read_enable(read_enable), .read_addr(read_addr), .read_wid(read_wid),
        .read_valid(read_valid), .read_data(read_data),
        .rop_busy(rop_busy), .rop_rt_idx(rop_rt_idx),
        .rop_sample_idx(rop_sample_idx), .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    int unsigned sh_rt [NW];
    int unsigned sh_sm [NW];
    int unsigned ac_rt [NW];
    int unsigned ac_sm [NW];
    bit          pend  [NW];
    bit          m_rv;
    logic [127:0] m_rd;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_word(input logic [11:0] addr, input int w);
        if (addr == BASE)               return sh_rt[w];
        else if (addr == BASE + 12'd1)  return sh_sm[w];
        else if (addr == BASE + 12'd3)  return pend[w] + ac_rt[w] * 16 + ac_sm[w] * 65536;
        else                            return 0;
    endfunction

    // One clock: predict from the current inputs, advance, then compare everything
    task automatic step();
        int unsigned n_sh_rt [NW];
        int unsigned n_sh_sm [NW];
        int unsigned n_ac_rt [NW];
        int unsigned n_ac_sm [NW];
        bit          n_pend  [NW];
        int unsigned val = 0;
        bit          found = 0;
        bit          commit_req;
        int unsigned word;
        for (int i = 0; i < NT; i++) begin
            if (!found && write_tmask[i]) begin
                val = write_data[i*32 +: 32];
                found = 1;
            end
        end
        for (int w = 0; w < NW; w++) begin
            n_sh_rt[w] = sh_rt[w]; n_sh_sm[w] = sh_sm[w];
            n_ac_rt[w] = ac_rt[w]; n_ac_sm[w] = ac_sm[w]; n_pend[w] = pend[w];
        end
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                n_sh_rt[w] = 0; n_sh_sm[w] = 0; n_ac_rt[w] = 0; n_ac_sm[w] = 0; n_pend[w] = 0;
            end
            m_rv = 0;
            m_rd = '0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                commit_req = write_enable && found && write_addr == BASE + 12'd2 && write_wid == w;
                if (!rop_busy[w] && (pend[w] || commit_req)) begin
                    n_ac_rt[w] = sh_rt[w];
                    n_ac_sm[w] = sh_sm[w];
                    n_pend[w]  = 0;
                end else if (commit_req) begin
                    n_pend[w] = 1;
                end
            end
            if (write_enable && found && write_addr == BASE)
                n_sh_rt[write_wid] = val % (1 << RTB);
            if (write_enable && found && write_addr == BASE + 12'd1)
                n_sh_sm[write_wid] = val % (1 << SB);
            if (read_enable) begin
                word = model_word(read_addr, read_wid);
                m_rd = {word, word, word, word};
            end
            m_rv = read_enable;
        end
        @(posedge clk);
        #1;
        for (int w = 0; w < NW; w++) begin
            sh_rt[w] = n_sh_rt[w]; sh_sm[w] = n_sh_sm[w];
            ac_rt[w] = n_ac_rt[w]; ac_sm[w] = n_ac_sm[w]; pend[w] = n_pend[w];
        end
        for (int w = 0; w < NW; w++) begin
            check_val("rop_rt_idx", rop_rt_idx[w*RTB +: RTB], ac_rt[w]);
            check_val("rop_sample_idx", rop_sample_idx[w*SB +: SB], ac_sm[w]);
            check_val("commit_pending", commit_pending[w], pend[w]);
        end
        check_val("read_valid", read_valid, m_rv);
        check_val("read_data", read_data, m_rd);
    endtask

    task automatic idle();
        reset = 1'b0; write_enable = 1'b0; write_addr = 12'd0; write_wid = 2'd0;
        write_tmask = 4'd0; write_data = '0; read_enable = 1'b0; read_addr = 12'd0; read_wid = 2'd0;
    endtask

    task automatic wr(input int w, input logic [11:0] addr, input logic [3:0] tm, input logic [31:0] d);
        idle();
        write_enable = 1'b1; write_wid = 2'(w); write_addr = addr; write_tmask = tm;
        write_data = {d, d, d, d};
        step();
    endtask

    task automatic rd(input int w, input logic [11:0] addr);
        idle();
        read_enable = 1'b1; read_wid = 2'(w); read_addr = addr;
        step();
    endtask

    initial begin
        idle();
        rop_busy = 4'd0;
        for (int w = 0; w < NW; w++) begin
            sh_rt[w] = 0; sh_sm[w] = 0; ac_rt[w] = 0; ac_sm[w] = 0; pend[w] = 0;
        end
        m_rv = 0; m_rd = '0;
        reset = 1'b1; step(); step();
        check_val("reset_read_data", read_data, 128'd0);

        // RT_IDX=5 to wid 1 from lane 2, other lanes 7
        idle();
        write_enable = 1'b1; write_wid = 2'd1; write_addr = BASE; write_tmask = 4'b0100;
        write_data = {32'd7, 32'd5, 32'd7, 32'd7};
        step();
        check_val("rt_not_active", rop_rt_idx[5:3], 3'd0);
        rd(1, BASE);
        check_val("rd_rt5", read_data, {4{32'd5}});
        check_val("rd_rt5_valid", read_valid, 1'b1);

        // truncation, empty tmask, unmapped address
        wr(1, BASE, 4'b0001, 32'h1D);
        wr(1, BASE, 4'b0000, 32'h3);
        wr(1, BASE + 12'd7, 4'b1111, 32'h3);
        rd(1, BASE + 12'd7);
        check_val("rd_unmapped", read_data, 128'd0);
        rd(1, BASE);
        check_val("rd_trunc", read_data, {4{32'd5}});

        // immediate commit on idle warp 2
        wr(2, BASE, 4'b1000, 32'd3);
        wr(2, BASE + 12'd1, 4'b0010, 32'd1);
        wr(2, BASE + 12'd2, 4'b0001, 32'hFFFF);
        check_val("commit_rt2", rop_rt_idx[8:6], 3'd3);
        check_val("commit_sm2", rop_sample_idx[5:4], 2'd1);

        // deferred commit on warp 0, overlapping with a shadow write
        wr(0, BASE, 4'b0001, 32'd6);
        wr(0, BASE + 12'd1, 4'b0001, 32'd1);
        wr(0, BASE + 12'd2, 4'b0001, 32'd0);
        rop_busy = 4'b0001;
        wr(0, BASE, 4'b0001, 32'd4);
        wr(0, BASE + 12'd2, 4'b0001, 32'd0);
        wr(0, BASE + 12'd2, 4'b0001, 32'd0);
        check_val("pending0", commit_pending[0], 1'b1);
        check_val("held_rt0", rop_rt_idx[2:0], 3'd6);
        rd(0, BASE + 12'd3);
        check_val("status0", read_data[31:0], 32'h0001_0061);
        idle();
        rop_busy = 4'b0000;
        write_enable = 1'b1; write_wid = 2'd0; write_addr = BASE + 12'd1;
        write_tmask = 4'b0001; write_data = {4{32'd2}};
        step();
        check_val("defer_rt0", rop_rt_idx[2:0], 3'd4);
        check_val("defer_sm0", rop_sample_idx[1:0], 2'd1);
        check_val("defer_clr0", commit_pending[0], 1'b0);
        rd(0, BASE + 12'd1);
        check_val("shadow_sm0", read_data[31:0], 32'd2);

        // reset drops a pending commit on warp 3
        rop_busy = 4'b1000;
        wr(3, BASE, 4'b0001, 32'd7);
        wr(3, BASE + 12'd2, 4'b0001, 32'd0);
        idle(); reset = 1'b1; step();
        check_val("rst_pending", commit_pending, 4'd0);
        idle(); rop_busy = 4'b0000;
        step(); step();
        check_val("rst_active3", rop_rt_idx[11:9], 3'd0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            reset        = ($urandom_range(0, 63) == 0);
            write_enable = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: write_addr = BASE;
                1: write_addr = BASE + 12'd1;
                2: write_addr = BASE + 12'd2;
                3: write_addr = BASE + 12'd3;
                4: write_addr = BASE + 12'd7;
                default: write_addr = BASE;
            endcase
            write_wid   = 2'($urandom_range(0, 3));
            write_tmask = 4'($urandom_range(0, 15));
            for (int i = 0; i < NT; i++) write_data[i*32 +: 32] = $urandom;
            read_enable = $urandom_range(0, 1);
            read_addr   = BASE + 12'($urandom_range(0, 4));
            read_wid    = 2'($urandom_range(0, 3));
            rop_busy    = 4'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
